cpu16_bus_responder: RTL and testbench

Bus responder (memory/peripheral side) for the CPU16 16-bit single-master bus. Decodes the CPU's registered address, returns registered read data one cycle later (matching the CPU's single RAM wait state), absorbs writes into word RAM and a small I/O block, and throttles the CPU through `hold` when the byte-output FIFO nears full. Sits between the CPU16 core and the board-level character sink.

---
 rtl/cpu16_bus_pkg.sv | 40 ++++
 rtl/cpu16_resp_fifo.sv | 55 +++++
 rtl/cpu16_bus_responder.sv | 122 ++++++++++++
 tb/tb_cpu16_bus_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_bus_pkg.sv
// Shared constants for the CPU16 bus responder: I/O register addresses,
// RAM window limit, STATUS bit positions and the address decoder.
package cpu16_bus_pkg;

    localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
    localparam logic [15:0] ADDR_TIMER  = 16'hFF01;
    localparam logic [15:0] ADDR_STATUS = 16'hFF02;
    localparam logic [15:0] ADDR_COUNT  = 16'hFF03;
    localparam logic [15:0] RAM_LIMIT   = 16'h8000;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_HOLD  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TXDATA,
        SEL_TIMER,
        SEL_STATUS,
        SEL_COUNT,
        SEL_NONE
    } sel_t;

    function automatic sel_t decode(input logic [15:0] addr);
        sel_t sel;
        if (addr < RAM_LIMIT) begin
            sel = SEL_RAM;
        end else begin
            case (addr)
                ADDR_TXDATA: sel = SEL_TXDATA;
                ADDR_TIMER:  sel = SEL_TIMER;
                ADDR_STATUS: sel = SEL_STATUS;
                ADDR_COUNT:  sel = SEL_COUNT;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu16_resp_fifo.sv
// Synchronous FIFO for the responder's TX byte path. A push while full is
// accepted only when a pop frees the head slot on the same edge.
module cpu16_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu16_bus_responder.sv
// CPU16 bus responder: RAM, TX FIFO, STATUS/COUNT registers and hold throttle.
// Optional free-running TIMER register is built when CPU16_RESP_TIMER_EN is defined.
module cpu16_bus_responder
    import cpu16_bus_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        write,
    output logic [15:0] rdata,
    output logic        hold,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    sel_t             sel;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic [15:0]      timer_val;
    logic [15:0]      status;
    logic [15:0]      rd_next;
    logic [15:0]      ram [2**RAM_AW];

    // Assert immediately, release two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign sel      = decode(address);
    assign push     = write && (sel == SEL_TXDATA);
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;
    assign hold     = !rst_int_n || (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

    cpu16_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (push),
        .pop       (pop),
        .push_data (wdata[7:0]),
        .head      (tx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (write && (sel == SEL_STATUS) && wdata[STAT_OVF]) begin
            overflow <= 1'b0;
        end
    end

`ifdef CPU16_RESP_TIMER_EN
    logic [15:0] timer;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            timer <= '0;
        end else if (write && (sel == SEL_TIMER)) begin
            timer <= wdata;
        end else begin
            timer <= timer + 16'd1;
        end
    end
    assign timer_val = timer;
`else
    assign timer_val = '0;
`endif

    // RAM is not reset; its read port reads the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (write && (sel == SEL_RAM)) begin
            ram[address[RAM_AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_HOLD]  = hold;
        status[STAT_OVF]   = overflow;
    end

    always_comb begin
        rd_next = '0;
        case (sel)
            SEL_RAM:    rd_next = ram[address[RAM_AW-1:0]];
            SEL_TIMER:  rd_next = timer_val;
            SEL_STATUS: rd_next = status;
            SEL_COUNT:  rd_next = 16'(fifo_count);
            default:    rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) rdata <= '0;
        else            rdata <= rd_next;
    end

endmodule

// File: tb/tb_cpu16_bus_responder.sv
// Self-checking bench for cpu16_bus_responder: directed cases with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_cpu16_bus_responder;

    localparam int RAM_AW = 10;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] address = 16'hF000;
    logic [15:0] wdata = 16'h0000;
    logic        write = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] rdata;
    logic        hold;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_ram [1024];
    bit          m_known [1024];
    logic [7:0]  m_q [$];
    bit          m_ovf = 1'b0;
    logic [15:0] m_timer = 16'h0000;
    bit          m_timer_known = 1'b0;
    logic [15:0] exp_rdata = 16'h0000;
    bit          exp_known = 1'b0;
    bit          chk_en = 1'b0;

    cpu16_bus_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .wdata    (wdata),
        .write    (write),
        .rdata    (rdata),
        .hold     (hold),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model of one rising edge using the inputs currently on the bus.
    task automatic model_step();
        logic [15:0] rd;
        bit          known;
        bit          pop;
        rd    = 16'h0000;
        known = 1'b1;
        if (address < 16'h8000) begin
            rd    = m_ram[address[9:0]];
            known = m_known[address[9:0]];
        end else begin
            case (address)
                16'hFF01: begin
`ifdef CPU16_RESP_TIMER_EN
                    rd    = m_timer;
                    known = m_timer_known;
`endif
                end
                16'hFF02: rd = {13'b0, m_ovf, 1'(m_q.size() >= DEPTH - 1), 1'(m_q.size() == 0)};
                16'hFF03: rd = 16'(m_q.size());
                default:  rd = 16'h0000;
            endcase
        end
        pop = (m_q.size() > 0) && tx_ready;
        if (pop) void'(m_q.pop_front());
        if (write) begin
            if (address < 16'h8000) begin
                m_ram[address[9:0]]   = wdata;
                m_known[address[9:0]] = 1'b1;
            end else if (address == 16'hFF00) begin
                if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
                else                    m_ovf = 1'b1;
            end else if (address == 16'hFF02 && wdata[2]) begin
                m_ovf = 1'b0;
            end
        end
        if (write && address == 16'hFF01) begin
            m_timer       = wdata;
            m_timer_known = 1'b1;
        end else begin
            m_timer = m_timer + 16'd1;
        end
        exp_rdata = rd;
        exp_known = known;
    endtask

    task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        address  = a;
        wdata    = d;
        write    = w;
        tx_ready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        m_q.delete();
        m_ovf         = 1'b0;
        m_timer_known = 1'b0;
        repeat (3) cycle(16'hF000, 16'h0000, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("hold_after_reset", {15'b0, hold}, 16'h0000);
        chk("txv_after_reset", {15'b0, tx_valid}, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_hold", {15'b0, hold}, {15'b0, 1'(m_q.size() >= DEPTH - 1)});
            chk("model_tx_valid", {15'b0, tx_valid}, {15'b0, 1'(m_q.size() > 0)});
            chk("model_tx_data", {8'b0, tx_data}, {8'b0, (m_q.size() > 0) ? m_q[0] : 8'h00});
            if (exp_known) chk("model_rdata", rdata, exp_rdata);
        end
    end

    initial begin
        logic [15:0] a;
        int          r;
        for (int i = 0; i < 1024; i++) begin
            m_ram[i]   = 16'h0000;
            m_known[i] = 1'b0;
        end

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", {15'b0, hold}, 16'h0001);
        chk("reset_rdata", rdata, 16'h0000);
        chk("reset_txv", {15'b0, tx_valid}, 16'h0000);
        chk("reset_txdata", {8'b0, tx_data}, 16'h0000);
        release_reset();

        // RAM write/read, alias and read-during-write
        cycle(16'h0005, 16'h1234, 1'b1, 1'b0);
        cycle(16'h0005, 16'h0000, 1'b0, 1'b0);
        chk("ram_read", rdata, 16'h1234);
        cycle(16'h0405, 16'h0000, 1'b0, 1'b0);
        chk("ram_alias", rdata, 16'h1234);
        cycle(16'h0005, 16'hBEEF, 1'b1, 1'b0);
        chk("ram_rdw_old", rdata, 16'h1234);
        cycle(16'h4005, 16'h0000, 1'b0, 1'b0);
        chk("ram_new_alias", rdata, 16'hBEEF);

        // Unmapped space
        cycle(16'h0000, 16'h00AA, 1'b1, 1'b0);
        cycle(16'h9000, 16'h0000, 1'b0, 1'b0);
        chk("unmapped_read", rdata, 16'h0000);
        cycle(16'h9000, 16'hDEAD, 1'b1, 1'b0);
        cycle(16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("unmapped_no_write", rdata, 16'h00AA);
        cycle(16'hFF00, 16'h0000, 1'b0, 1'b0);
        chk("txdata_reads_zero", rdata, 16'h0000);

        // FIFO fill to hold, then drain in order
        cycle(16'hFF00, 16'h0041, 1'b1, 1'b0);
        cycle(16'hFF00, 16'h0042, 1'b1, 1'b0);
        chk("hold_at_2", {15'b0, hold}, 16'h0000);
        cycle(16'hFF00, 16'h0043, 1'b1, 1'b0);
        chk("hold_at_3", {15'b0, hold}, 16'h0001);
        cycle(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("count_3", rdata, 16'h0003);
        chk("head_41", {8'b0, tx_data}, 16'h0041);
        cycle(16'hF000, 16'h0000, 1'b0, 1'b1);
        chk("head_42", {8'b0, tx_data}, 16'h0042);
        chk("hold_drop_at_2", {15'b0, hold}, 16'h0000);
        cycle(16'hF000, 16'h0000, 1'b0, 1'b1);
        chk("head_43", {8'b0, tx_data}, 16'h0043);
        cycle(16'hF000, 16'h0000, 1'b0, 1'b1);
        chk("drained", {15'b0, tx_valid}, 16'h0000);

        // Overflow: fifth push dropped, sticky flag, cleared via STATUS
        for (int i = 0; i < 4; i++) cycle(16'hFF00, 16'(16'h10 + i), 1'b1, 1'b0);
        cycle(16'hFF00, 16'h0055, 1'b1, 1'b0);
        cycle(16'hFF02, 16'h0000, 1'b0, 1'b0);
        chk("status_ovf", rdata, 16'h0006);
        cycle(16'hFF02, 16'h0004, 1'b1, 1'b0);
        cycle(16'hFF02, 16'h0000, 1'b0, 1'b0);
        chk("status_cleared", rdata, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_order", {8'b0, tx_data}, 16'(16'h10 + i));
            cycle(16'hF000, 16'h0000, 1'b0, 1'b1);
        end
        chk("ovf_drain_empty", {15'b0, tx_valid}, 16'h0000);

        // Timer: 0xFFFE loaded, three reads later the counter has wrapped to 0
        cycle(16'hFF01, 16'hFFFE, 1'b1, 1'b0);
        repeat (3) cycle(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("timer_wrap", rdata, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin
                    a = 16'h0040 + 16'($urandom_range(0, 31));
                    a = a | ($urandom_range(0, 1) ? 16'h0400 : 16'h0000)
                          | ($urandom_range(0, 1) ? 16'h4000 : 16'h0000);
                end
                3, 4:    a = 16'hFF00;
                5:       a = 16'hFF01;
                6:       a = 16'hFF02;
                7:       a = 16'hFF03;
                default: a = 16'h8000 + 16'($urandom_range(0, 16'h7EFF));
            endcase
            cycle(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end

        // Reset asserted in the middle of a drain
        for (int i = 0; i < 3; i++) cycle(16'hFF00, 16'(16'h60 + i), 1'b1, 1'b0);
        cycle(16'hFF02, 16'h0004, 1'b1, 1'b0);
        cycle(16'hF000, 16'h0000, 1'b0, 1'b1);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_txv", {15'b0, tx_valid}, 16'h0000);
        chk("midreset_hold", {15'b0, hold}, 16'h0001);
        chk("midreset_rdata", rdata, 16'h0000);
        chk("midreset_txdata", {8'b0, tx_data}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        cycle(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("count_after_reset", rdata, 16'h0000);
        cycle(16'h0005, 16'h0000, 1'b0, 1'b0);
        chk("ram_retained", rdata, 16'hBEEF);
        cycle(16'hF000, 16'h0000, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
